// File: rtl/mem_wait_ctrl.sv
// MEM-stage controller for a multi-cycle synchronous SRAM: maps byte addresses to
// SRAM words, sequences the access over WAIT_CYCLES and freezes the pipeline meanwhile.
module mem_wait_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int BASE_ADDR       = 1024,
  parameter int WAIT_CYCLES     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_r_en,
  input  logic                       mem_w_en,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       ready,
  output logic                       addr_err,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_wdata,
  input  logic [DATA_WIDTH-1:0]      sram_rdata,
  output logic                       sram_ce_n,
  output logic                       sram_we_n
);

  localparam int ALIGN = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      counter;
  logic                  is_read;
  logic                  req;
  logic [ADDR_WIDTH-1:0] offset;

  // Below base, misaligned within a word, or beyond the last SRAM word.
  function automatic logic access_ok(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [ADDR_WIDTH-1:0] off);
    logic below, misaligned, out_of_range;
    below        = addr < BASE;
    misaligned   = off[ALIGN-1:0] != '0;
    out_of_range = (off >> (ALIGN + SRAM_ADDR_WIDTH)) != '0;
    return !below && !misaligned && !out_of_range;
  endfunction

  assign req    = mem_r_en | mem_w_en;
  assign offset = address - BASE;
  assign ready  = ~req | (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      is_read    <= 1'b0;
      rdata      <= '0;
      addr_err   <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (access_ok(address, offset)) begin
              // A simultaneous read and write request is treated as a write.
              sram_addr  <= offset[ALIGN +: SRAM_ADDR_WIDTH];
              sram_wdata <= wdata;
              sram_ce_n  <= 1'b0;
              sram_we_n  <= ~mem_w_en;
              is_read    <= ~mem_w_en;
              counter    <= CNT_W'(WAIT_CYCLES - 1);
              state      <= ACCESS;
            end else begin
              addr_err <= 1'b1;
              rdata    <= '0;
              state    <= DONE;
            end
          end
        end
        ACCESS: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            if (is_read) begin
              rdata <= sram_rdata;
            end
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          addr_err <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_wait_ctrl.md
Name: mem_wait_ctrl

Overview:
- Parametrised memory-stage controller between the MEM pipeline stage and an external synchronous SRAM with multi-cycle access.
- Translates the byte address from the ALU result into an SRAM word address with a configurable base offset.
- Sequences reads and writes over WAIT_CYCLES cycles and drives a ready signal that freezes the whole pipeline until the access completes.
- Flags misaligned and out-of-range accesses instead of performing them.

Parameters:
- DATA_WIDTH, 32, data word width in bits (32 or 64).
- ADDR_WIDTH, 32, pipeline byte-address width.
- SRAM_ADDR_WIDTH, 16, SRAM word-address width.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 4, SRAM access cycles per transfer (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- mem_r_en  input  1  load request from MEM stage; level, held while ready=0.
- mem_w_en  input  1  store request from MEM stage; level, held while ready=0.
- address  input  ADDR_WIDTH  byte address (ALU result).
- wdata  input  DATA_WIDTH  store data (val_rm).
- rdata  output  DATA_WIDTH  load result, valid when ready=1 in DONE.
- ready  output  1  0 freezes the pipeline (IF/ID/EXE/MEM registers hold).
- addr_err  output  1  one-cycle pulse on a rejected access.
- sram_addr  output  SRAM_ADDR_WIDTH  SRAM word address.
- sram_wdata  output  DATA_WIDTH  SRAM write data.
- sram_rdata  input  DATA_WIDTH  SRAM read data.
- sram_ce_n  output  1  SRAM chip enable, active low.
- sram_we_n  output  1  SRAM write enable, active low.

Behaviour:
- Reset (async, any state): state=IDLE; counter=0; rdata=0; addr_err=0; sram_ce_n=1; sram_we_n=1; sram_addr=0; sram_wdata=0.
- ready is combinational: ready = ~(mem_r_en|mem_w_en) | (state==DONE). It is 1 when idle with no request.
- Offset = address - BASE_ADDR. Word index = offset >> log2(DATA_WIDTH/8).
- A request is invalid if any of the following hold:
  - address < BASE_ADDR;
  - offset is not aligned to DATA_WIDTH/8;
  - word index >= 2**SRAM_ADDR_WIDTH.
- If both mem_r_en and mem_w_en are 1, the access is a write. rdata is not updated.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, valid request: latch word index into sram_addr and wdata into sram_wdata. Assert sram_ce_n=0, and sram_we_n=0 for a write. Set counter=WAIT_CYCLES-1. Go to ACCESS.
  - IDLE, invalid request: no SRAM activity. Go to DONE with addr_err=1 and rdata=0.
  - ACCESS: SRAM controls are held stable.
    - counter>0: decrement.
    - counter==0: for a read, register rdata<=sram_rdata; release sram_ce_n and sram_we_n to 1; go to DONE.
  - DONE: ready=1 for exactly one cycle. addr_err clears on leaving DONE. Go to IDLE unconditionally.
- A request present in the cycle after DONE is a new access.
- Latency: ready is 0 for WAIT_CYCLES+1 cycles from the first request cycle, then 1 for one cycle. An invalid access takes 1 freeze cycle.
- rdata holds its last value until the next completed read or error.
- A request that drops while in ACCESS (external flush): the access still completes in full; DONE is still entered.
- Reset mid-ACCESS: abort immediately. The SRAM write may be partial; that is acceptable.
- Address, data and SRAM address are latched in IDLE; input changes during ACCESS are ignored.

Test Plan:
1. Reset, then mem_w_en=1, address=1024, wdata=0xDEADBEEF, WAIT_CYCLES=4 -> ready=0 for 5 cycles; sram_addr=0, sram_we_n=0 for 4 cycles; ready=1 in cycle 6; the SRAM model holds 0xDEADBEEF at word 0.
2. Read back: mem_r_en=1, address=1024 -> after 5 freeze cycles ready=1, rdata=0xDEADBEEF; sram_we_n stays 1 throughout.
3. Boundary addresses:
   - address=1024+4*(2**16-1) -> sram_addr=0xFFFF, normal access.
   - address=1024+4*2**16 -> 1 freeze cycle, addr_err=1, rdata=0, sram_ce_n stays 1.
4. Rejected accesses: address=1026 (misaligned) and address=1020 (below base) -> each gives addr_err pulse, 1-cycle freeze, no SRAM enable.
5. Back-to-back loads to words 2 and 3 with the request held continuously -> two separate 5-cycle freezes, each followed by a single DONE cycle with the correct data; IDLE occupies the cycle between them.
6. Remaining configurations:
   - Assert rst in the 2nd ACCESS cycle -> immediately sram_ce_n=1, state IDLE, ready follows the request.
   - DATA_WIDTH=64, WAIT_CYCLES=1: address=1032 -> sram_addr=1, 2-cycle freeze.
   - Simultaneous mem_r_en and mem_w_en -> write performed, rdata unchanged.
